trinity_handover_rx: RTL

TRINITY_HANDOVER_RX -- requirements
Module: trinity_handover_rx

---
 rtl/arkhe_trinity_pkg.sv | 35 +++
 rtl/trinity_event_fifo.sv | 89 ++++++++
 rtl/trinity_handover_rx.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/arkhe_trinity_pkg.sv
// -----------------------------------------------------------------------------
// arkhe_trinity_pkg
// Shared definitions for the Trinity handover receive path:
//   - field widths (priority, braid count, timestamp)
//   - Q16.16 constants PHI and KAPPA
//   - coalescer FSM state encoding
//   - ev_rec_t, the coalesced event record stored in the event FIFO
// -----------------------------------------------------------------------------
package arkhe_trinity_pkg;

   localparam int PRIO_W  = 4;
   localparam int BRAID_W = 4;
   localparam int TIME_W  = 16;
   localparam int PHASE_W = 32;

   // Golden ratio conjugate (0.6180) in Q16.16.
   localparam logic signed [PHASE_W-1:0] PHI   = 32'sh0000_9E37;
   // Coupling constant (0.7071) in Q16.16.
   localparam logic signed [PHASE_W-1:0] KAPPA = 32'sh0000_B505;

   localparam logic [BRAID_W-1:0] BRAID_MAX = '1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } coal_state_e;

   typedef struct packed {
      logic [PRIO_W-1:0]         prio;
      logic signed [PHASE_W-1:0] phase;
      logic [BRAID_W-1:0]        braid;
      logic [TIME_W-1:0]         ts;
   } ev_rec_t;

endpackage

// File: rtl/trinity_event_fifo.sv
// -----------------------------------------------------------------------------
// trinity_event_fifo
// Record FIFO with a registered read port. Storage is a DEPTH-entry array with
// extra-bit wrap-around pointers plus one output register. Total occupancy
// (array + output register) never exceeds DEPTH. A write into a full FIFO is
// accepted only when a read happens in the same cycle.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr_valid_i          write request
//   wr_data_i           record to write
//   wr_ready_o          write will be accepted this cycle
//   rd_valid_o          registered: rd_data_o holds a record
//   rd_data_o           head record, all-zero when rd_valid_o=0
//   rd_ready_i          consumer takes the head record
// -----------------------------------------------------------------------------
module trinity_event_fifo #(
   parameter int  DEPTH = 8,
   parameter type rec_t = logic [7:0]
) (
   input  logic clk,
   input  logic rst,
   input  logic wr_valid_i,
   input  rec_t wr_data_i,
   output logic wr_ready_o,
   output logic rd_valid_o,
   output rec_t rd_data_o,
   input  logic rd_ready_i
);

   localparam int AW = $clog2(DEPTH);
   typedef logic [AW:0] ptr_t;

   rec_t mem_q [DEPTH];
   ptr_t wr_ptr_q;
   ptr_t rd_ptr_q;
   logic out_valid_q;
   rec_t out_data_q;

   ptr_t mem_cnt;
   logic pop;
   logic full;
   logic load;
   logic wr_en;

   // NOTE: every signal assigned in an always_comb gets a default at the top so no latch is inferred.
   always_comb begin
      mem_cnt    = wr_ptr_q - rd_ptr_q;
      pop        = out_valid_q && rd_ready_i;
      // The output register counts toward capacity.
      full       = (mem_cnt + ptr_t'(out_valid_q)) == ptr_t'(DEPTH);
      wr_ready_o = !full || pop;
      wr_en      = wr_valid_i && wr_ready_o;
      // Refill the output register whenever it is empty or being drained.
      load       = (mem_cnt != '0) && (!out_valid_q || pop);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + ptr_t'(1);
         end
         if (load) begin
            rd_ptr_q    <= rd_ptr_q + ptr_t'(1);
            out_valid_q <= 1'b1;
            out_data_q  <= mem_q[rd_ptr_q[AW-1:0]];
         end else if (pop) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
         end
      end
   end

   // NOTE: the storage array has no reset; the pointers guarantee an unwritten slot is never read out.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
      end
   end

   assign rd_valid_o = out_valid_q;
   assign rd_data_o  = out_data_q;

endmodule

// File: rtl/trinity_handover_rx.sv
// -----------------------------------------------------------------------------
// trinity_handover_rx
// Coalesces bursts of handover strobes from the Trinity core into single event
// records and queues them for a ready/valid consumer.
// A strobe in IDLE opens a record; strobes within HOLDOFF cycles of the last
// one merge into it (max priority, saturating braid count). HOLDOFF quiet
// cycles after the last strobe the record is pushed into the event FIFO.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   handover_strobe                event pulse
//   priority_level, phase_z_in     sampled with the strobe
//   ev_valid / ev_ready            record handshake (ev_valid is registered)
//   ev_priority, ev_phase,
//   ev_braid, ev_time              record fields, zero when ev_valid=0
//   drop_count                     records lost to a full FIFO, saturating
//   overflow                       sticky, set on the first drop
// -----------------------------------------------------------------------------
module trinity_handover_rx
   import arkhe_trinity_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int HOLDOFF = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      handover_strobe,
   input  logic [PRIO_W-1:0]         priority_level,
   input  logic signed [PHASE_W-1:0] phase_z_in,
   output logic                      ev_valid,
   input  logic                      ev_ready,
   output logic [PRIO_W-1:0]         ev_priority,
   output logic signed [PHASE_W-1:0] ev_phase,
   output logic [BRAID_W-1:0]        ev_braid,
   output logic [TIME_W-1:0]         ev_time,
   output logic [15:0]               drop_count,
   output logic                      overflow
);

   localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF);

   coal_state_e       state_q;
   coal_state_e       state_d;
   logic [7:0]        hold_cnt_q;
   logic [7:0]        hold_cnt_d;
   ev_rec_t           rec_q;
   ev_rec_t           rec_d;
   logic [TIME_W-1:0] ts_q;
   logic [15:0]       drop_count_q;
   logic              overflow_q;

   logic    open_rec;
   logic    merge_rec;
   logic    push;
   logic    fifo_wr_ready;
   logic    drop;
   ev_rec_t head;

   // ---------------- coalescer FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- coalescer FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (handover_strobe) state_d = ST_HOLD;
         ST_HOLD: if (!handover_strobe && hold_cnt_q == 8'd1) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- coalescer FSM: outputs ----------------
   // A strobe in the cycle the counter reaches 1 merges instead of pushing.
   always_comb begin
      open_rec  = 1'b0;
      merge_rec = 1'b0;
      push      = 1'b0;
      case (state_q)
         ST_IDLE: open_rec = handover_strobe;
         ST_HOLD: begin
            merge_rec = handover_strobe;
            push      = !handover_strobe && (hold_cnt_q == 8'd1);
         end
         default: ;
      endcase
   end

   // ---------------- record and holdoff counter ----------------
   always_comb begin
      rec_d      = rec_q;
      hold_cnt_d = hold_cnt_q;
      if (open_rec) begin
         rec_d.prio  = priority_level;
         rec_d.phase = phase_z_in;
         rec_d.braid = BRAID_W'(1);
         rec_d.ts    = ts_q;
         hold_cnt_d  = HOLD_LOAD;
      end else if (merge_rec) begin
         if (rec_q.braid != BRAID_MAX) rec_d.braid = rec_q.braid + BRAID_W'(1);
         if (priority_level > rec_q.prio) rec_d.prio = priority_level;
         hold_cnt_d = HOLD_LOAD;
      end else if (state_q == ST_HOLD) begin
         // Reaches 0 on the push edge, leaving the counter clear in IDLE.
         hold_cnt_d = hold_cnt_q - 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ts_q       <= '0;
         hold_cnt_q <= '0;
         rec_q      <= '0;
      end else begin
         ts_q       <= ts_q + TIME_W'(1);
         hold_cnt_q <= hold_cnt_d;
         rec_q      <= rec_d;
      end
   end

   // ---------------- event FIFO ----------------
   trinity_event_fifo #(
      .DEPTH (DEPTH),
      .rec_t (ev_rec_t)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .wr_valid_i (push),
      .wr_data_i  (rec_q),
      .wr_ready_o (fifo_wr_ready),
      .rd_valid_o (ev_valid),
      .rd_data_o  (head),
      .rd_ready_i (ev_ready)
   );

   // ---------------- drop accounting ----------------
   assign drop = push && !fifo_wr_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_count_q <= '0;
         overflow_q   <= 1'b0;
      end else if (drop) begin
         overflow_q <= 1'b1;
         if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
      end
   end

   assign ev_priority = head.prio;
   assign ev_phase    = head.phase;
   assign ev_braid    = head.braid;
   assign ev_time     = head.ts;
   assign drop_count  = drop_count_q;
   assign overflow    = overflow_q;

endmodule
